a2d_conv_sched: RTL and testbench

Conversion scheduler that sequences the 16-bit SPI monarch shared with the external ADC128S converter. On each `nxt` trigger it reads the next of four channels in round-robin order: left load cell, right load cell, steer pot, battery. It handles the converter's two-transaction protocol, where the channel is selected in transaction 1 and the result returns in transaction 2. Converted values are registered for the steer-enable, authorization and battery-monitor logic in Segway.

---
 rtl/a2d_pkg.sv | 25 ++
 rtl/a2d_tmo_cnt.sv | 42 ++++
 rtl/a2d_conv_sched.sv | 173 +++++++++++++++++
 tb/tb_a2d_conv_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S conversion scheduler.
// Covers the sequencer states, the default converter channels and the SPI command builder.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND1 = 3'd1,
        WAIT1 = 3'd2,
        GAP   = 3'd3,
        SEND2 = 3'd4,
        WAIT2 = 3'd5
    } a2d_state_t;

    localparam logic [2:0] A2D_CH_LFT   = 3'd0;
    localparam logic [2:0] A2D_CH_RGHT  = 3'd4;
    localparam logic [2:0] A2D_CH_STEER = 3'd5;
    localparam logic [2:0] A2D_CH_BATT  = 3'd6;
    localparam int         A2D_TMO_CYC  = 1024;

    // The converter takes the channel address in bits [13:11] of the command word.
    function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_tmo_cnt.sv
// Watchdog counter for SPI transactions: a loadable up-counter with clear and enable.
// Its terminal flag fires in the cycle whose increment would reach TMO_CYC-1.
module a2d_tmo_cnt #(
    parameter int  TMO_CYC = 1024,
    localparam int CW      = $clog2(TMO_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TMO_CYC - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/a2d_conv_sched.sv
// Round-robin conversion scheduler for the ADC128S behind the shared SPI monarch.
// Each conversion uses two SPI transactions: the first selects the channel, the second returns its result.
module a2d_conv_sched
    import a2d_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = A2D_CH_LFT,
    parameter logic [2:0] CH_RGHT  = A2D_CH_RGHT,
    parameter logic [2:0] CH_STEER = A2D_CH_STEER,
    parameter logic [2:0] CH_BATT  = A2D_CH_BATT,
    parameter int         TMO_CYC  = A2D_TMO_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic [1:0]  rr_ptr,
    output logic        tmo_err
);

    localparam int CW = $clog2(TMO_CYC);

    a2d_state_t  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] steer_q, steer_d;
    logic [11:0] batt_q, batt_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;
    logic        tmo_err_q, tmo_err_d;

    logic        wrt_c;
    logic        tmo_clr;
    logic        tmo_en;
    logic        tmo_tc;
    logic [2:0]  sel_chnl;

    // Converter status bits ride in the top nibble of the reply and are not needed.
    logic [3:0]  unused_rd_hi;
    assign unused_rd_hi = rd_data[15:12];

    a2d_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .ld     (1'b0),
        .ld_val ({CW{1'b0}}),
        .tc     (tmo_tc)
    );

    always_comb begin
        sel_chnl = CH_LFT;
        case (rr_ptr_q)
            2'd0:    sel_chnl = CH_LFT;
            2'd1:    sel_chnl = CH_RGHT;
            2'd2:    sel_chnl = CH_STEER;
            default: sel_chnl = CH_BATT;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rr_ptr_d    = rr_ptr_q;
        lft_d       = lft_q;
        rght_d      = rght_q;
        steer_d     = steer_q;
        batt_d      = batt_q;
        cnv_cmplt_d = 1'b0;
        tmo_err_d   = tmo_err_q;
        wrt_c       = 1'b0;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (nxt) begin
                    cmd_d   = a2d_cmd(sel_chnl);
                    state_d = SEND1;
                end
            end
            SEND1: begin
                wrt_c   = 1'b1;
                tmo_clr = 1'b1;
                state_d = WAIT1;
            end
            WAIT1: begin
                tmo_en = 1'b1;
                if (done) begin
                    state_d = GAP;
                end else if (tmo_tc) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            // One cycle with the bus idle keeps SS_n high long enough between transactions.
            GAP: begin
                state_d = SEND2;
            end
            SEND2: begin
                wrt_c   = 1'b1;
                tmo_clr = 1'b1;
                state_d = WAIT2;
            end
            WAIT2: begin
                tmo_en = 1'b1;
                if (done) begin
                    case (rr_ptr_q)
                        2'd0:    lft_d   = rd_data[11:0];
                        2'd1:    rght_d  = rd_data[11:0];
                        2'd2:    steer_d = rd_data[11:0];
                        default: batt_d  = rd_data[11:0];
                    endcase
                    cnv_cmplt_d = 1'b1;
                    rr_ptr_d    = rr_ptr_q + 2'd1;
                    state_d     = IDLE;
                end else if (tmo_tc) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= 16'h0000;
            rr_ptr_q    <= 2'd0;
            lft_q       <= 12'h000;
            rght_q      <= 12'h000;
            steer_q     <= 12'h000;
            batt_q      <= 12'h000;
            cnv_cmplt_q <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rr_ptr_q    <= rr_ptr_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            steer_q     <= steer_d;
            batt_q      <= batt_d;
            cnv_cmplt_q <= cnv_cmplt_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign wrt       = wrt_c;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cnv_cmplt_q;
    assign rr_ptr    = rr_ptr_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched with a behavioural SPI monarch/ADC responder.
// The responder answers each wrt after a programmable delay, returning a per-channel reply word.
module tb_a2d_conv_sched;

    logic        clk;
    logic        rst;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic [1:0]  rr_ptr;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cmplt_n  = 0;
    int c0;
    int w0, d0, k0;

    logic [15:0] wrt_cmds[$];
    int          wrt_cyc[$];
    int          done_cyc[$];
    int          cmplt_cyc[$];

    logic [15:0] rsp_val[4];
    bit          rsp_en  = 1'b1;
    int          rsp_dly = 2;

    a2d_conv_sched #(
        .TMO_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .rr_ptr    (rr_ptr),
        .tmo_err   (tmo_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrt) begin
            wrt_cmds.push_back(cmd);
            wrt_cyc.push_back(cyc);
        end
        if (cnv_cmplt) begin
            cmplt_n <= cmplt_n + 1;
            cmplt_cyc.push_back(cyc);
        end
    end

    function automatic logic [1:0] slot_of(input logic [15:0] c);
        case (c[13:11])
            3'd4:    return 2'd1;
            3'd5:    return 2'd2;
            3'd6:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // SPI monarch / converter model: one done pulse rsp_dly cycles after each wrt.
    initial begin : responder
        bit         pend;
        int         pend_left;
        logic [1:0] pend_slot;
        pend      = 1'b0;
        pend_left = 0;
        pend_slot = 2'd0;
        done      = 1'b0;
        rd_data   = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (pend) begin
                pend_left = pend_left - 1;
                if (pend_left == 0) begin
                    done    = 1'b1;
                    rd_data = rsp_val[pend_slot];
                    done_cyc.push_back(cyc);
                    pend    = 1'b0;
                end
            end else if (wrt && rsp_en) begin
                pend      = 1'b1;
                pend_left = rsp_dly;
                pend_slot = slot_of(cmd);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        c0  = cyc;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic mark();
        w0 = wrt_cmds.size();
        d0 = done_cyc.size();
        k0 = cmplt_n;
    endtask

    initial begin
        rst        = 1'b1;
        nxt        = 1'b0;
        rsp_val[0] = 16'h0200;
        rsp_val[1] = 16'h0210;
        rsp_val[2] = 16'h07FF;
        rsp_val[3] = 16'h0900;
        repeat (3) @(negedge clk);
        chk("rst_wrt", 32'(wrt), 32'h0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_regs", {lft_ld, rght_ld} | 32'(steer_pot) | 32'(batt), 32'h0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("rst_tmo_cnv", {tmo_err, cnv_cmplt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset pulsed while WAIT2 is pending; the late done must be ignored.
        rsp_dly = 6;
        mark();
        pulse_nxt();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wrt", 32'(wrt), 32'h0);
        repeat (25) @(negedge clk);
        chk("midrst_nwrt", 32'(wrt_cmds.size() - w0), 32'd2);
        chk("midrst_late_done", 32'(done_cyc.size() - d0), 32'd2);
        chk("midrst_lft", 32'(lft_ld), 32'h0);
        chk("midrst_cmplt", 32'(cmplt_n - k0), 32'd0);
        chk("midrst_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("midrst_tmo", 32'(tmo_err), 32'd0);

        // Single conversion of the left load cell.
        rsp_dly = 2;
        mark();
        pulse_nxt();
        repeat (10) @(negedge clk);
        chk("one_nwrt", 32'(wrt_cmds.size() - w0), 32'd2);
        chk("one_latency", 32'(wrt_cyc[w0] - c0), 32'd1);
        chk("one_cmd1", 32'(wrt_cmds[w0]), 32'h0000);
        chk("one_cmd2", 32'(wrt_cmds[w0+1]), 32'h0000);
        chk("one_gap", 32'(wrt_cyc[w0+1] - done_cyc[d0]), 32'd2);
        chk("one_lft", 32'(lft_ld), 32'h200);
        chk("one_cmplt_n", 32'(cmplt_n - k0), 32'd1);
        chk("one_cmplt_cyc", 32'(cmplt_cyc[k0] - done_cyc[d0+1]), 32'd1);
        chk("one_rr_ptr", 32'(rr_ptr), 32'd1);

        // Remaining three channels, wrapping the round-robin pointer.
        mark();
        for (int i = 0; i < 3; i++) begin
            pulse_nxt();
            repeat (10) @(negedge clk);
        end
        chk("rr_cmd_rght", 32'(wrt_cmds[w0]), 32'h2000);
        chk("rr_cmd_steer", 32'(wrt_cmds[w0+2]), 32'h2800);
        chk("rr_cmd_batt", 32'(wrt_cmds[w0+4]), 32'h3000);
        chk("rr_cmd_batt2", 32'(wrt_cmds[w0+5]), 32'h3000);
        chk("rr_rght", 32'(rght_ld), 32'h210);
        chk("rr_steer", 32'(steer_pot), 32'h7FF);
        chk("rr_batt", 32'(batt), 32'h900);
        chk("rr_lft_kept", 32'(lft_ld), 32'h200);
        chk("rr_wrap", 32'(rr_ptr), 32'd0);
        chk("rr_cmplt_n", 32'(cmplt_n - k0), 32'd3);

        // nxt held high for exactly three conversions (8-cycle period incl. an IDLE cycle).
        rsp_val[0] = 16'h0ABC;
        rsp_val[1] = 16'h0DEF;
        rsp_val[2] = 16'h0123;
        mark();
        nxt = 1'b1;
        repeat (24) @(negedge clk);
        nxt = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_cmplt_n", 32'(cmplt_n - k0), 32'd3);
        chk("held_nwrt", 32'(wrt_cmds.size() - w0), 32'd6);
        chk("held_period1", 32'(wrt_cyc[w0+2] - wrt_cyc[w0]), 32'd8);
        chk("held_period2", 32'(wrt_cyc[w0+4] - wrt_cyc[w0+2]), 32'd8);
        chk("held_lft", 32'(lft_ld), 32'hABC);
        chk("held_steer", 32'(steer_pot), 32'h123);
        chk("held_rr_ptr", 32'(rr_ptr), 32'd3);

        // Converter silent in WAIT1: timeout after 15 WAIT1 cycles.
        rsp_en = 1'b0;
        mark();
        pulse_nxt();
        repeat (15) @(negedge clk);
        chk("tmo_not_yet", 32'(tmo_err), 32'd0);
        @(negedge clk);
        chk("tmo_set", 32'(tmo_err), 32'd1);
        chk("tmo_rr_ptr", 32'(rr_ptr), 32'd3);
        chk("tmo_nwrt", 32'(wrt_cmds.size() - w0), 32'd1);
        repeat (4) @(negedge clk);
        chk("tmo_no_cmplt", 32'(cmplt_n - k0), 32'd0);

        // Retry the battery channel; upper reply nibble must be dropped.
        rsp_en     = 1'b1;
        rsp_val[3] = 16'hF123;
        mark();
        pulse_nxt();
        repeat (10) @(negedge clk);
        chk("retry_cmd", 32'(wrt_cmds[w0]), 32'h3000);
        chk("retry_batt", 32'(batt), 32'h123);
        chk("retry_tmo_sticky", 32'(tmo_err), 32'd1);
        chk("retry_rr_ptr", 32'(rr_ptr), 32'd0);
        chk("retry_cmplt_n", 32'(cmplt_n - k0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
